// File: rtl/ins_mem_pkg.sv
// Shared constants for the instruction-memory subsystem: arbiter FSM states
// and index-width helper, reused by the processor top.
package ins_mem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Width of an index into n items; never zero so single-core builds still elaborate.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ins_mem_arbiter_rr.sv
// Round-robin selector: scans from (last_grant+1) mod N and returns the first
// requester as a one-hot grant plus its index.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] index
);

   logic             found;
   int unsigned      cand;
   logic [IDX_W-1:0] sel;

   always_comb begin
      gnt   = '0;
      index = '0;
      found = 1'b0;
      cand  = 32'd0;
      sel   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = (32'(last_grant) + i) % N;
         sel  = IDX_W'(cand);
         if (!found && req[sel]) begin
            gnt[sel] = 1'b1;
            index    = sel;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ins_mem_arbiter.sv
// Instruction-memory port arbiter: host programs the RAM in LOAD, cores fetch
// round-robin in RUN through a two-stage read pipeline, DRAIN lets reads retire.
module ins_mem_arbiter
   import ins_mem_pkg::*;
#(
   parameter int CORE_COUNT = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             load_req,
   input  logic                             host_wrEn,
   input  logic [ADDR_WIDTH-1:0]            host_addr,
   input  logic [WIDTH-1:0]                 host_dataIn,
   input  logic [CORE_COUNT-1:0]            core_req,
   input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
   output logic [CORE_COUNT-1:0]            core_gnt,
   output logic [CORE_COUNT-1:0]            core_rvalid,
   output logic [WIDTH-1:0]                 core_rdata,
   output logic                             ram_wrEn,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [WIDTH-1:0]                 ram_dataIn,
   input  logic [WIDTH-1:0]                 ram_dataOut,
   output logic                             running
);

   localparam int IDX_W = idx_width(CORE_COUNT);

   state_t                  state, state_next;
   logic [IDX_W-1:0]        last_grant, arb_idx, s1_idx;
   logic                    s1_valid, grant;
   logic [CORE_COUNT-1:0]   arb_req, arb_gnt, rv_next;
   logic [ADDR_WIDTH-1:0]   win_addr;

   assign arb_req  = (state == ST_RUN) ? core_req : '0;
   assign grant    = |arb_gnt;
   assign core_gnt = arb_gnt;
   assign running  = (state == ST_RUN);

   rr_arbiter #(
      .N     (CORE_COUNT),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (arb_req),
      .last_grant (last_grant),
      .gnt        (arb_gnt),
      .index      (arb_idx)
   );

   always_comb begin
      win_addr = '0;
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
         if (arb_gnt[i]) win_addr = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < CORE_COUNT; i++) begin
         rv_next[i] = s1_valid && (s1_idx == IDX_W'(i));
      end
   end

   always_comb begin
      state_next = state;
      ram_wrEn   = 1'b0;
      ram_addr   = '0;
      ram_dataIn = '0;
      unique case (state)
         ST_LOAD: begin
            ram_wrEn   = host_wrEn & ~rst;
            ram_addr   = host_addr;
            ram_dataIn = host_dataIn;
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (grant) ram_addr = win_addr;
            if (load_req) state_next = ST_DRAIN;
         end
         // No grants here, so the read in stage 1 retires this cycle and both stages are empty next cycle.
         ST_DRAIN: state_next = ST_LOAD;
         default:  state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_LOAD;
         last_grant  <= IDX_W'(CORE_COUNT - 1);
         s1_valid    <= 1'b0;
         s1_idx      <= '0;
         core_rvalid <= '0;
         core_rdata  <= '0;
      end else begin
         state       <= state_next;
         s1_valid    <= grant;
         if (grant) begin
            s1_idx     <= arb_idx;
            last_grant <= arb_idx;
         end
         core_rvalid <= rv_next;
         if (s1_valid) core_rdata <= ram_dataOut;
      end
   end

endmodule

// File: tb/tb_ins_mem_arbiter.sv
// Directed bench for ins_mem_arbiter: per-cycle vector table plus a reset-in-flight
// sequence, with a registered-read RAM model behind the memory port.
module tb_ins_mem_arbiter;

   logic        clk, rst, start, load_req, host_wrEn;
   logic [7:0]  host_addr, host_dataIn;
   logic [3:0]  core_req, core_gnt, core_rvalid;
   logic [31:0] core_addr;
   logic [7:0]  core_rdata, ram_addr, ram_dataIn, ram_dataOut;
   logic        ram_wrEn, running;

   int checks = 0;
   int errors = 0;

   ins_mem_arbiter #(
      .CORE_COUNT (4),
      .WIDTH      (8),
      .DEPTH      (256)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_req    (load_req),
      .host_wrEn   (host_wrEn),
      .host_addr   (host_addr),
      .host_dataIn (host_dataIn),
      .core_req    (core_req),
      .core_addr   (core_addr),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .ram_wrEn    (ram_wrEn),
      .ram_addr    (ram_addr),
      .ram_dataIn  (ram_dataIn),
      .ram_dataOut (ram_dataOut),
      .running     (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (ram_wrEn) mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= mem[ram_addr];
   end

   typedef struct {
      logic        start, load_req, wr;
      logic [7:0]  haddr, hdata;
      logic [3:0]  req;
      logic [31:0] caddr;
      logic [3:0]  gnt, rv;
      logic [7:0]  rdata, raddr;
      logic        run, wen;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic lr, input logic wr, input logic [7:0] ha,
                        input logic [7:0] hd, input logic [3:0] rq, input logic [31:0] ca);
      start = st; load_req = lr; host_wrEn = wr; host_addr = ha; host_dataIn = hd;
      core_req = rq; core_addr = ca;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // start,lreq,wr,haddr,hdata,req,caddr | gnt,rv,rdata,raddr,run,wen
      vecs[0]  = '{1'b0,1'b0,1'b1,8'h03,8'hA5,4'hF,32'h0,        4'h0,4'h0,8'h00,8'h03,1'b0,1'b1};
      vecs[1]  = '{1'b0,1'b0,1'b1,8'h07,8'h3C,4'hF,32'h0,        4'h0,4'h0,8'h00,8'h07,1'b0,1'b1};
      vecs[2]  = '{1'b1,1'b0,1'b0,8'h00,8'h00,4'hF,32'h0,        4'h0,4'h0,8'h00,8'h00,1'b0,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b1,8'h09,8'h55,4'h4,32'h00030000, 4'h4,4'h0,8'h00,8'h03,1'b1,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h0,32'h00030000, 4'h0,4'h0,8'h00,8'h00,1'b1,1'b0};
      vecs[5]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h0,32'h0,        4'h0,4'h4,8'hA5,8'h00,1'b1,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h8,32'h07000000, 4'h8,4'h0,8'hA5,8'h07,1'b1,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h8,32'h07000000, 4'h8,4'h0,8'hA5,8'h07,1'b1,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h8,32'h07000000, 4'h8,4'h8,8'h3C,8'h07,1'b1,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h8,32'h07000000, 4'h8,4'h8,8'h3C,8'h07,1'b1,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h8,32'h07000000, 4'h8,4'h8,8'h3C,8'h07,1'b1,1'b0};
      vecs[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'hF,32'h07030703, 4'h1,4'h8,8'h3C,8'h03,1'b1,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'hF,32'h07030703, 4'h2,4'h8,8'h3C,8'h07,1'b1,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'hF,32'h07030703, 4'h4,4'h1,8'hA5,8'h03,1'b1,1'b0};
      vecs[14] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'hF,32'h07030703, 4'h8,4'h2,8'h3C,8'h07,1'b1,1'b0};
      vecs[15] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'hF,32'h07030703, 4'h1,4'h4,8'hA5,8'h03,1'b1,1'b0};
      vecs[16] = '{1'b0,1'b1,1'b0,8'h00,8'h00,4'h3,32'h07030703, 4'h2,4'h8,8'h3C,8'h07,1'b1,1'b0};
      vecs[17] = '{1'b1,1'b0,1'b0,8'h00,8'h00,4'h3,32'h07030703, 4'h0,4'h1,8'hA5,8'h00,1'b0,1'b0};
      vecs[18] = '{1'b0,1'b1,1'b1,8'h07,8'h3C,4'h3,32'h07030703, 4'h0,4'h2,8'h3C,8'h07,1'b0,1'b1};
      vecs[19] = '{1'b1,1'b0,1'b0,8'h05,8'h00,4'h3,32'h07030703, 4'h0,4'h0,8'h3C,8'h05,1'b0,1'b0};
      vecs[20] = '{1'b0,1'b0,1'b0,8'h00,8'h00,4'h4,32'h07030703, 4'h4,4'h0,8'h3C,8'h03,1'b1,1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 8'h03, 8'hA5, 4'hF, 32'h0);
      @(negedge clk);
      check("reset gnt",     32'(core_gnt),    32'h0);
      check("reset running", 32'(running),     32'h0);
      check("reset wrEn",    32'(ram_wrEn),    32'h0);
      check("reset rvalid",  32'(core_rvalid), 32'h0);
      check("reset rdata",   32'(core_rdata),  32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      host_wrEn = 1'b0;

      for (int i = 0; i < 21; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].start, vecs[i].load_req, vecs[i].wr, vecs[i].haddr, vecs[i].hdata,
               vecs[i].req, vecs[i].caddr);
         @(negedge clk);
         check($sformatf("row%0d gnt", i),      32'(core_gnt),    32'(vecs[i].gnt));
         check($sformatf("row%0d rvalid", i),   32'(core_rvalid), 32'(vecs[i].rv));
         check($sformatf("row%0d rdata", i),    32'(core_rdata),  32'(vecs[i].rdata));
         check($sformatf("row%0d ram_addr", i), 32'(ram_addr),    32'(vecs[i].raddr));
         check($sformatf("row%0d running", i),  32'(running),     32'(vecs[i].run));
         check($sformatf("row%0d wrEn", i),     32'(ram_wrEn),    32'(vecs[i].wen));
         if (vecs[i].wen)
            check($sformatf("row%0d dataIn", i), 32'(ram_dataIn), 32'(vecs[i].hdata));
      end

      // Reset one cycle after the row-20 grant: that read must never complete.
      @(posedge clk); #1;
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 8'h07, 8'h3C, 4'hF, 32'h07030703);
      @(negedge clk);
      check("midrun rst gnt",     32'(core_gnt),    32'h0);
      check("midrun rst running", 32'(running),     32'h0);
      check("midrun rst wrEn",    32'(ram_wrEn),    32'h0);
      check("midrun rst rvalid",  32'(core_rvalid), 32'h0);
      check("midrun rst rdata",   32'(core_rdata),  32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post rst load wrEn", 32'(ram_wrEn),    32'h1);
      check("post rst rvalid",    32'(core_rvalid), 32'h0);
      check("post rst gnt",       32'(core_gnt),    32'h0);
      @(posedge clk); #1;
      host_wrEn = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check("post rst rvalid2", 32'(core_rvalid), 32'h0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("rerun first gnt",  32'(core_gnt), 32'h1);
      check("rerun ram_addr",   32'(ram_addr), 32'h03);
      check("rerun running",    32'(running),  32'h1);
      @(posedge clk); #1;
      core_req = 4'h0;
      @(negedge clk);
      check("rerun rvalid T+1", 32'(core_rvalid), 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rerun rvalid T+2", 32'(core_rvalid), 32'h1);
      check("rerun rdata T+2",  32'(core_rdata),  32'hA5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ins_mem_arbiter.md
INS_MEM_ARBITER -- requirements
Module: ins_mem_arbiter

Interface
REQ-001 The block SHALL have parameter CORE_COUNT, default 4: number of requesting cores.
REQ-002 The block SHALL have parameter WIDTH, default 8: instruction word width.
REQ-003 The block SHALL have parameter DEPTH, default 256: instruction memory words.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH): address width.
REQ-005 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 The block SHALL have port start, input, 1: pulse, LOAD->RUN.
REQ-008 The block SHALL have port load_req, input, 1: pulse, RUN->DRAIN->LOAD.
REQ-009 The block SHALL have port host_wrEn, input, 1: host program write strobe.
REQ-010 The block SHALL have port host_addr, input, ADDR_WIDTH: host write address.
REQ-011 The block SHALL have port host_dataIn, input, WIDTH: host write data.
REQ-012 The block SHALL have port core_req, input, CORE_COUNT: per-core fetch request, held until granted.
REQ-013 The block SHALL have port core_addr, input, CORE_COUNT*ADDR_WIDTH: packed per-core fetch addresses, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 The block SHALL have port core_gnt, output, CORE_COUNT: one-hot grant, combinational, same cycle as acceptance.
REQ-015 The block SHALL have port core_rvalid, output, CORE_COUNT: one-hot read-data valid, registered.
REQ-016 The block SHALL have port core_rdata, output, WIDTH: broadcast read data, qualified by core_rvalid.
REQ-017 The block SHALL have port ram_wrEn, output, 1: memory write enable.
REQ-018 The block SHALL have port ram_addr, output, ADDR_WIDTH: memory address (memory registers it).
REQ-019 The block SHALL have port ram_dataIn, output, WIDTH: memory write data.
REQ-020 The block SHALL have port ram_dataOut, input, WIDTH: memory read data, valid the cycle after address capture.
REQ-021 The block SHALL have port running, output, 1: high in RUN state only.

Function
REQ-022 The FSM SHALL have states LOAD, RUN and DRAIN.
REQ-023 In LOAD: ram_wrEn=host_wrEn, ram_addr=host_addr, ram_dataIn=host_dataIn; core_gnt=0; start moves the FSM to RUN next cycle.
REQ-024 In RUN: ram_wrEn=0; host_wrEn is ignored; each cycle at most one core is granted.
REQ-025 In RUN, load_req moves the FSM to DRAIN; a request present in that same cycle is still granted.
REQ-026 In DRAIN: no grants; the FSM moves to LOAD when both pipeline stages are empty (2 cycles after the last grant).
REQ-027 start outside LOAD, and load_req outside RUN, SHALL be ignored.
REQ-028 Arbitration SHALL be round-robin: the search starts at index (last_grant+1) mod CORE_COUNT; last_grant updates only on a grant.
REQ-029 On a grant: ram_addr=core_addr of the winner in the same cycle (T); stage-1 registers valid and the winner index at the end of T.
REQ-030 In T+1, stage-2 captures ram_dataOut into core_rdata and sets core_rvalid[winner]; both are visible in T+2. Grant-to-rvalid latency is therefore 2 cycles.
REQ-031 Throughput SHALL be one grant per cycle with back-to-back grants; rvalid order matches grant order.
REQ-032 A core may re-request in the cycle after its grant; with a single requester it SHALL be granted every cycle.
REQ-033 core_rvalid SHALL be low in any cycle with no completing read; core_rdata holds its last value.
REQ-034 When idle (no grant and not in LOAD), ram_addr SHALL be 0 and ram_wrEn SHALL be 0.

Reset
REQ-035 rst SHALL asynchronously force: state=LOAD, last_grant=CORE_COUNT-1 (so core 0 wins first), stage-1/2 valid=0, core_rvalid=0, core_rdata=0.
REQ-036 Combinational outputs in reset SHALL be core_gnt=0, running=0, ram_wrEn=0.
REQ-037 Reset mid-RUN SHALL discard in-flight reads; no rvalid is produced for them.

Structure
REQ-038 The FSM state encoding (LOAD/RUN/DRAIN) SHALL be defined as localparams in a shared constants package/include (ins_mem_pkg), reused by the processor top.
REQ-039 The round-robin selector SHALL be one sub-module, rr_arbiter (inputs: req, last_grant; outputs: one-hot gnt, index); FSM and pipeline stay in ins_mem_arbiter.

Verification
REQ-040 Bench SHALL cover: reset; LOAD; host writes 0xA5 @ 3 and 0x3C @ 7 -> ram_wrEn pulses with those values; core_req=0xF meanwhile -> core_gnt=0.
REQ-041 Bench SHALL cover: start, then core 2 requests addr 3 in cycle T -> core_gnt=0b0100 in T; core_rvalid=0b0100 and core_rdata=0xA5 in T+2.
REQ-042 Bench SHALL cover: all 4 cores requesting continuously -> grants 0,1,2,3,0,... one per cycle; rvalid follows 2 cycles later in the same order.
REQ-043 Bench SHALL cover: load_req while cores 0 and 1 are requesting -> the same-cycle grant completes, then no further grants; running=0; LOAD entered exactly 2 cycles after the last grant.
REQ-044 Bench SHALL cover: rst asserted one cycle after a grant -> no rvalid for that grant; state=LOAD; the next RUN grants core 0 first.
REQ-045 Bench SHALL cover: single requester core 3 for 5 cycles with addr 7 -> 5 consecutive grants; 5 rvalids with core_rdata=0x3C.
